// File: rtl/cmd_frame_parser_pkg.sv
// Shared opcodes, command-type encodings and FSM state codes for the UART command frame parser.
package cmd_frame_pkg;

    localparam logic [7:0] OPC_WR      = 8'hAA;
    localparam logic [7:0] OPC_RD      = 8'hBB;
    localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
    localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

    typedef enum logic [1:0] {
        CMD_WR      = 2'b00,
        CMD_RD      = 2'b01,
        CMD_ALU_OP  = 2'b10,
        CMD_ALU_NOP = 2'b11
    } cmd_type_e;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_GET_ADDR = 3'd1;
    localparam logic [2:0] ST_GET_DATA = 3'd2;
    localparam logic [2:0] ST_GET_OPA  = 3'd3;
    localparam logic [2:0] ST_GET_OPB  = 3'd4;
    localparam logic [2:0] ST_GET_FUN  = 3'd5;
    localparam logic [2:0] ST_HOLD     = 3'd6;

    // True while a frame is partially collected and more bytes are awaited.
    function automatic logic is_get_state(input logic [2:0] s);
        return (s == ST_GET_ADDR) || (s == ST_GET_DATA) || (s == ST_GET_OPA) ||
               (s == ST_GET_OPB)  || (s == ST_GET_FUN);
    endfunction

endpackage

// File: rtl/cmd_frame_parser_if.sv
// Byte-in / command-out bundle between DATA_SYNC, the frame parser (master) and SYS_CTRL (slave).
interface cmd_frame_if #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) ();

    logic [DSIZE-1:0] RX_P_DATA;
    logic             RX_D_VLD;
    logic             CMD_RDY;
    logic             CMD_VLD;
    logic [1:0]       CMD_TYPE;
    logic [ASIZE-1:0] CMD_ADDR;
    logic [DSIZE-1:0] CMD_DATA0;
    logic [DSIZE-1:0] CMD_DATA1;
    logic [3:0]       CMD_FUN;
    logic             FRAME_ERR;
    logic             OVERRUN;

    modport master (
        input  RX_P_DATA, RX_D_VLD, CMD_RDY,
        output CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_DATA0, CMD_DATA1, CMD_FUN,
               FRAME_ERR, OVERRUN
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, CMD_RDY,
        input  CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_DATA0, CMD_DATA1, CMD_FUN,
               FRAME_ERR, OVERRUN
    );

endinterface

// File: rtl/cmd_frame_parser_frame_timer.sv
// Inter-byte watchdog: counts idle cycles inside a frame and flags when TIMEOUT-1 is reached.
module frame_timer #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // Held at zero outside a frame so every new frame starts from a clean count.
    always_comb begin
        if (clr_i || !en_i) cnt_d = '0;
        else                cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/cmd_frame_parser.sv
// UART command frame parser: collects WR/RD/ALU frames and presents one command via valid/ready.
// Optional inter-byte timeout abort is enabled by defining CMD_TIMEOUT_EN.
module cmd_frame_parser
    import cmd_frame_pkg::*;
#(
    parameter int DSIZE   = 8,
    parameter int ASIZE   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic          CLK,
    input  logic          RST,
    cmd_frame_if.master   bus
);

    if (DSIZE < 8 || ASIZE > DSIZE || TIMEOUT < 2) begin : g_bad_params
        $error("cmd_frame_parser: DSIZE must be >= 8, ASIZE <= DSIZE, TIMEOUT >= 2");
    end

    logic [2:0]       state_q, state_d;
    cmd_type_e        type_q, type_d;
    logic [ASIZE-1:0] addr_q, addr_d;
    logic [DSIZE-1:0] data0_q, data0_d;
    logic [DSIZE-1:0] data1_q, data1_d;
    logic [3:0]       fun_q, fun_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;

    logic             rx;
    logic             take_op;
    logic             timeout_hit;
    logic             hold;

    assign rx      = bus.RX_D_VLD;
    assign hold    = (state_q == ST_HOLD);
    // Accepting in the same cycle as a new byte lets that byte open the next frame.
    assign take_op = rx && ((state_q == ST_IDLE) || (hold && bus.CMD_RDY));

`ifdef CMD_TIMEOUT_EN
    logic timer_expired;

    frame_timer #(.TIMEOUT(TIMEOUT)) u_frame_timer (
        .clk       (CLK),
        .rst_n     (RST),
        .clr_i     (rx),
        .en_i      (is_get_state(state_q)),
        .expired_o (timer_expired)
    );

    assign timeout_hit = is_get_state(state_q) && !rx && timer_expired;
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path through the case infers a latch.
        state_d = state_q;
        type_d  = type_q;
        addr_d  = addr_q;
        data0_d = data0_q;
        data1_d = data1_q;
        fun_d   = fun_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        case (state_q)
            ST_HOLD: begin
                if (bus.CMD_RDY) state_d = ST_IDLE;
                else if (rx)     ovr_d   = 1'b1;
            end
            ST_GET_ADDR: if (rx) begin
                addr_d  = bus.RX_P_DATA[ASIZE-1:0];
                state_d = (type_q == CMD_WR) ? ST_GET_DATA : ST_HOLD;
            end
            ST_GET_DATA: if (rx) begin
                data0_d = bus.RX_P_DATA;
                state_d = ST_HOLD;
            end
            ST_GET_OPA: if (rx) begin
                data0_d = bus.RX_P_DATA;
                state_d = ST_GET_OPB;
            end
            ST_GET_OPB: if (rx) begin
                data1_d = bus.RX_P_DATA;
                state_d = ST_GET_FUN;
            end
            ST_GET_FUN: if (rx) begin
                fun_d   = bus.RX_P_DATA[3:0];
                state_d = ST_HOLD;
            end
            default: ;
        endcase

        // Fields not carried by the new command must read back as zero.
        if (take_op) begin
            addr_d  = '0;
            data0_d = '0;
            data1_d = '0;
            fun_d   = '0;
            case (bus.RX_P_DATA[7:0])
                OPC_WR:      begin type_d = CMD_WR;      state_d = ST_GET_ADDR; end
                OPC_RD:      begin type_d = CMD_RD;      state_d = ST_GET_ADDR; end
                OPC_ALU_OP:  begin type_d = CMD_ALU_OP;  state_d = ST_GET_OPA;  end
                OPC_ALU_NOP: begin type_d = CMD_ALU_NOP; state_d = ST_GET_FUN;  end
                default:     begin ferr_d = 1'b1;        state_d = ST_IDLE;     end
            endcase
        end

        if (timeout_hit) begin
            state_d = ST_IDLE;
            ferr_d  = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            type_q  <= CMD_WR;
            addr_q  <= '0;
            data0_q <= '0;
            data1_q <= '0;
            fun_q   <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q <= state_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            fun_q   <= fun_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Partial frames stay invisible: command fields only show while the command is offered.
    assign bus.CMD_VLD   = hold;
    assign bus.CMD_TYPE  = {2{hold}} & type_q;
    assign bus.CMD_ADDR  = {ASIZE{hold}} & addr_q;
    assign bus.CMD_DATA0 = {DSIZE{hold}} & data0_q;
    assign bus.CMD_DATA1 = {DSIZE{hold}} & data1_q;
    assign bus.CMD_FUN   = {4{hold}} & fun_q;
    assign bus.FRAME_ERR = ferr_q;
    assign bus.OVERRUN   = ovr_q;

endmodule
